// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetcher with a DEPTH-entry {pc,data} FIFO toward decode.
// Redirects flush the FIFO and mark outstanding fetches stale so their responses are dropped.
module instr_fetch_queue #(
    parameter int WORD_LENGTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WORD_LENGTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [WORD_LENGTH-1:0] mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [WORD_LENGTH-1:0] mem_resp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [WORD_LENGTH-1:0] instr_out,
    output logic [WORD_LENGTH-1:0] instr_pc,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WORD_LENGTH-1:0] pc_mem [DEPTH];
    logic [WORD_LENGTH-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, inflight, stale;
    logic [CW+1:0] occupancy;
    logic [WORD_LENGTH-1:0] fetch_pc, resp_pc, redirect_base;
    logic run, accept, keep, drop, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stale fetches still occupy a slot until their response drains.
    assign occupancy     = (CW+2)'(count) + (CW+2)'(inflight) + (CW+2)'(stale);
    assign mem_req_valid = run && !redirect_valid && (occupancy < (CW+2)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;
    assign keep          = mem_resp_valid && (stale == '0);
    assign drop          = mem_resp_valid && (stale != '0);
    assign instr_valid   = count != '0;
    assign pop           = instr_valid && instr_ready;
    assign instr_out     = data_mem[rd_ptr];
    assign instr_pc      = pc_mem[rd_ptr];
    assign redirect_base = {redirect_pc[WORD_LENGTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            stale    <= '0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                stale    <= stale + inflight + CW'(accept) - CW'(mem_resp_valid);
                inflight <= '0;
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + WORD_LENGTH'(4);
                inflight <= inflight + CW'(accept) - CW'(keep);
                if (drop)
                    stale <= stale - CW'(1);
                if (keep) begin
                    pc_mem[wr_ptr]   <= resp_pc;
                    data_mem[wr_ptr] <= mem_resp_data;
                    wr_ptr           <= nxt(wr_ptr);
                    resp_pc          <= resp_pc + WORD_LENGTH'(4);
                end
                if (pop)
                    rd_ptr <= nxt(rd_ptr);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end
endmodule
